instr_fetch: RTL and testbench

Instruction fetch stage for the single-cycle/multicycle datapath.
- Holds the PC and fetches instructions from instruction memory over a req/ack handshake.
- Presents each instruction with its PC to decode through a valid/ready interface.
- Also exposes the low REG_BITS-6 instruction bits (the 26-bit immediate/target field), which feed the sign-extension stage directly.
- Accepts redirects (branch/jump) from downstream.

---
 rtl/instr_fetch.sv | 108 ++++++++++
 tb/tb_instr_fetch.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, fetches over a req/ack handshake and
// hands each instruction with its PC to decode over valid/ready, honouring redirects.
module instr_fetch #(
  parameter int unsigned REG_BITS = 32,
  parameter logic [REG_BITS-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [REG_BITS-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [REG_BITS-1:0] imem_rdata,
  input  logic                redirect,
  input  logic [REG_BITS-1:0] redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [REG_BITS-1:0] out_instr,
  output logic [REG_BITS-1:0] out_pc,
  output logic [REG_BITS-7:0] out_imm
);

  typedef enum logic [1:0] {FETCH, FLUSH, WAIT_OUT} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [REG_BITS-1:0] r_pc;
  logic [REG_BITS-1:0] r_pendingPc;
  logic                r_outValid;
  logic [REG_BITS-1:0] r_outInstr;
  logic [REG_BITS-1:0] r_outPc;
  logic [REG_BITS-1:0] w_target;
  logic                w_capture;
  logic                w_dropAck;
  logic                w_accept;

  assign w_target = {redirect_pc[REG_BITS-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      FETCH: begin
        if (imem_ack && !redirect)      w_nextState = WAIT_OUT;
        else if (!imem_ack && redirect) w_nextState = FLUSH;
      end
      FLUSH:    if (imem_ack) w_nextState = FETCH;
      WAIT_OUT: if (out_ready || redirect) w_nextState = FETCH;
      default:  w_nextState = FETCH;
    endcase
  end

  // Strobes steering the datapath registers, derived from the current state.
  always_comb begin
    imem_req  = 1'b0;
    w_capture = 1'b0;
    w_dropAck = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      FETCH: begin
        imem_req  = !reset;
        w_capture = imem_ack && !redirect;
        w_dropAck = imem_ack && redirect;
      end
      FLUSH:    imem_req = !reset;
      WAIT_OUT: w_accept = out_ready || redirect;
      default:  imem_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_pendingPc <= RESET_PC;
      r_outValid  <= 1'b0;
      r_outInstr  <= '0;
      r_outPc     <= '0;
    end else begin
      if (w_capture) begin
        r_outInstr <= imem_rdata;
        r_outPc    <= r_pc;
        r_outValid <= 1'b1;
        r_pc       <= r_pc + REG_BITS'(4);
      end
      if (w_dropAck) r_pc <= w_target;
      if (r_state == FETCH && !imem_ack && redirect) r_pendingPc <= w_target;
      // In FLUSH the newest redirect wins, even when it lands with the ack.
      if (r_state == FLUSH) begin
        if (redirect) r_pendingPc <= w_target;
        if (imem_ack) r_pc <= redirect ? w_target : r_pendingPc;
      end
      if (w_accept) begin
        r_outValid <= 1'b0;
        if (redirect) r_pc <= w_target;
      end
    end
  end

  assign imem_addr = r_pc;
  assign out_valid = r_outValid;
  assign out_instr = r_outInstr;
  assign out_pc    = r_outPc;
  assign out_imm   = r_outInstr[REG_BITS-7:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: normal fetch, back-pressure, redirects in
// every state, PC wrap-around and reset while flushing.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [25:0] out_imm;

  int testsRun = 0;
  int testsFailed = 0;

  instr_fetch #(.REG_BITS(32), .RESET_PC(32'h100)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_imm(out_imm)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive inputs, then advance one clock and settle just after the edge.
  task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                               input logic redir, input logic [31:0] rpc, input logic ready);
    imem_ack    = ack;
    imem_rdata  = rdata;
    redirect    = redir;
    redirect_pc = rpc;
    out_ready   = ready;
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_pc", out_pc, 32'h0);
    checkOutput("rst_instr", out_instr, 32'h0);

    reset = 1'b0;
    #1;
    checkOutput("f0_req", 32'(imem_req), 32'd1);
    checkOutput("f0_addr", imem_addr, 32'h100);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("f0_hold", imem_addr, 32'h100);
    applyStimulus(1, 32'h0BFFFFFF, 0, 0, 1);
    checkOutput("f0_valid", 32'(out_valid), 32'd1);
    checkOutput("f0_instr", out_instr, 32'h0BFFFFFF);
    checkOutput("f0_imm", 32'(out_imm), 32'h03FFFFFF);
    checkOutput("f0_pc", out_pc, 32'h100);
    checkOutput("f0_reqlow", 32'(imem_req), 32'd0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("f1_valid", 32'(out_valid), 32'd0);
    checkOutput("f1_addr", imem_addr, 32'h104);
    checkOutput("f1_req", 32'(imem_req), 32'd1);

    // Back-pressure for five cycles; stray acks with no request are ignored.
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 32'h12345678, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_instr", out_instr, 32'h12345678);
      checkOutput("stall_pc", out_pc, 32'h104);
      checkOutput("stall_req", 32'(imem_req), 32'd0);
      applyStimulus(1, 32'hDEADBEEF, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("resume_req", 32'(imem_req), 32'd1);
    checkOutput("resume_addr", imem_addr, 32'h108);
    checkOutput("resume_valid", 32'(out_valid), 32'd0);

    // Redirect while the request is outstanding: address holds until ack.
    applyStimulus(0, 0, 1, 32'h203, 0);
    checkOutput("fl_addr0", imem_addr, 32'h108);
    checkOutput("fl_req0", 32'(imem_req), 32'd1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("fl_addr1", imem_addr, 32'h108);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 32'hCAFEF00D, 0, 0, 1);
    checkOutput("fl_valid", 32'(out_valid), 32'd0);
    checkOutput("fl_newaddr", imem_addr, 32'h200);

    // Redirect together with ack in FETCH.
    applyStimulus(1, 32'h11111111, 1, 32'h400, 1);
    checkOutput("ra_valid", 32'(out_valid), 32'd0);
    checkOutput("ra_addr", imem_addr, 32'h400);

    // Two redirects in flight, the later one arriving with the ack.
    applyStimulus(0, 0, 1, 32'h500, 1);
    checkOutput("ff_addr", imem_addr, 32'h400);
    applyStimulus(1, 32'h22222222, 1, 32'h602, 1);
    checkOutput("ff_newaddr", imem_addr, 32'h600);
    checkOutput("ff_valid", 32'(out_valid), 32'd0);

    // Redirect while holding an instruction drops it.
    applyStimulus(1, 32'hAAAA5555, 0, 0, 0);
    checkOutput("wo_valid", 32'(out_valid), 32'd1);
    checkOutput("wo_pc", out_pc, 32'h600);
    checkOutput("wo_imm", 32'(out_imm), 32'h02AA5555);
    applyStimulus(0, 0, 1, 32'hFFFFFFFF, 0);
    checkOutput("wo_drop", 32'(out_valid), 32'd0);
    checkOutput("wo_addr", imem_addr, 32'hFFFFFFFC);

    // PC wrap-around.
    applyStimulus(1, 32'h00000001, 0, 0, 1);
    checkOutput("wrap_pc", out_pc, 32'hFFFFFFFC);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("wrap_addr", imem_addr, 32'h0);

    // Reset while flushing.
    applyStimulus(0, 0, 1, 32'h700, 0);
    checkOutput("rf_addr", imem_addr, 32'h0);
    reset = 1'b1;
    #1;
    checkOutput("rf_reqcomb", 32'(imem_req), 32'd0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rf_req", 32'(imem_req), 32'd0);
    checkOutput("rf_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("rf_addr2", imem_addr, 32'h100);
    checkOutput("rf_req2", 32'(imem_req), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
